// File: rtl/sram_arbiter_if.sv
// Bus bundle for the video/host SRAM arbiter: requester handshakes plus the
// single-ported asynchronous SRAM pins.
interface sram_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt;
  logic              vid_rvalid;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [1:0]        host_be;
  logic              host_gnt;
  logic              host_rvalid;

  logic [DATA_W-1:0] rd_data;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  logic              ram_ce;
  logic              ram_oe;
  logic              ram_we;
  logic              ram_lb;
  logic              ram_hb;

  modport slave (
    input  vid_req, vid_addr, host_req, host_we, host_addr, host_wdata, host_be, ram_din,
    output vid_gnt, vid_rvalid, host_gnt, host_rvalid, rd_data,
           ram_addr, ram_dout, ram_ce, ram_oe, ram_we, ram_lb, ram_hb
  );

  modport master (
    output vid_req, vid_addr, host_req, host_we, host_addr, host_wdata, host_be,
    input  vid_gnt, vid_rvalid, host_gnt, host_rvalid, rd_data
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of an asynchronous SRAM: a read-only video port with
// priority and a read/write host port protected against starvation.
module sram_arbiter #(
  parameter int ADDR_W        = 18,
  parameter int DATA_W        = 16,
  parameter int HOST_MAX_WAIT = 16
) (
  input logic          clk,
  input logic          reset,
  sram_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(HOST_MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, RD, WR, WR_HOLD} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             grantable;
  logic             force_host;
  logic             host_blocked;
  logic             vid_gnt;
  logic             host_gnt;
  logic             pend_vid;
  logic             pend_host;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Arbitration and next-state; WR is the only state that cannot accept a transfer
  always_comb begin
    grantable    = 1'b0;
    force_host   = 1'b0;
    vid_gnt      = 1'b0;
    host_gnt     = 1'b0;
    host_blocked = 1'b0;
    state_next   = IDLE;
    grantable    = !reset && (state != WR);
    force_host   = (wait_cnt == CNT_W'(HOST_MAX_WAIT));
    if (grantable) begin
      if (bus.host_req && (force_host || !bus.vid_req)) begin
        host_gnt = 1'b1;
      end else if (bus.vid_req) begin
        vid_gnt = 1'b1;
      end else begin
        vid_gnt = 1'b0;
      end
    end else begin
      host_gnt = 1'b0;
    end
    host_blocked = grantable && bus.host_req && !host_gnt;
    if (host_gnt && bus.host_we) begin
      state_next = WR;
    end else if (host_gnt || vid_gnt) begin
      state_next = RD;
    end else if (state == WR) begin
      state_next = WR_HOLD;
    end else begin
      state_next = IDLE;
    end
  end

  assign bus.vid_gnt  = vid_gnt;
  assign bus.host_gnt = host_gnt;

  // Host starvation counter, saturating at the forcing threshold
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (host_gnt) begin
      wait_cnt <= '0;
    end else if (host_blocked && !force_host) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= wait_cnt;
    end
  end

  // Registered SRAM strobes, read pipeline and read-data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.ram_addr    <= '0;
      bus.ram_dout    <= '0;
      bus.ram_ce      <= 1'b0;
      bus.ram_oe      <= 1'b0;
      bus.ram_we      <= 1'b0;
      bus.ram_lb      <= 1'b0;
      bus.ram_hb      <= 1'b0;
      bus.rd_data     <= '0;
      bus.vid_rvalid  <= 1'b0;
      bus.host_rvalid <= 1'b0;
      pend_vid        <= 1'b0;
      pend_host       <= 1'b0;
    end else begin
      pend_vid        <= vid_gnt;
      pend_host       <= host_gnt && !bus.host_we;
      bus.vid_rvalid  <= pend_vid;
      bus.host_rvalid <= pend_host;
      if (pend_vid || pend_host) begin
        bus.rd_data <= bus.ram_din;
      end else begin
        bus.rd_data <= bus.rd_data;
      end
      if (vid_gnt) begin
        bus.ram_addr <= bus.vid_addr;
        bus.ram_ce   <= 1'b1;
        bus.ram_oe   <= 1'b1;
        bus.ram_we   <= 1'b0;
        bus.ram_lb   <= 1'b1;
        bus.ram_hb   <= 1'b1;
      end else if (host_gnt) begin
        bus.ram_addr <= bus.host_addr;
        bus.ram_ce   <= 1'b1;
        bus.ram_oe   <= !bus.host_we;
        bus.ram_we   <= bus.host_we;
        if (bus.host_we) begin
          bus.ram_dout <= bus.host_wdata;
          bus.ram_lb   <= bus.host_be[0];
          bus.ram_hb   <= bus.host_be[1];
        end else begin
          bus.ram_lb   <= 1'b1;
          bus.ram_hb   <= 1'b1;
        end
      end else if (state == WR) begin
        // Hold address, data and lanes one cycle past the write strobe
        bus.ram_ce <= 1'b1;
        bus.ram_oe <= 1'b0;
        bus.ram_we <= 1'b0;
      end else begin
        bus.ram_ce <= 1'b0;
        bus.ram_oe <= 1'b0;
        bus.ram_we <= 1'b0;
        bus.ram_lb <= 1'b0;
        bus.ram_hb <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: arbitration vector table, scoreboard of
// read data, and hand-written multi-cycle sequences.
module tb_sram_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  sram_arbiter_if #(.ADDR_W(18), .DATA_W(16)) bus ();

  sram_arbiter #(.ADDR_W(18), .DATA_W(16), .HOST_MAX_WAIT(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] data_of(input logic [17:0] a);
    return a[15:0] ^ 16'h85E5;
  endfunction

  // SRAM model: read data is a fixed function of the address on the pins
  assign bus.ram_din = data_of(bus.ram_addr);

  typedef struct {
    bit          is_vid;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  int vid_run = 0;
  int max_run = 0;
  int vid_rv_total = 0;
  int host_rv_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Push expected read results just before the accepting edge
  always begin
    @(negedge clk);
    #4;
    if (!reset) begin
      if (bus.vid_gnt && bus.vid_req) begin
        sb.push_back('{1'b1, data_of(bus.vid_addr)});
      end else if (bus.host_gnt && bus.host_req && !bus.host_we) begin
        sb.push_back('{1'b0, data_of(bus.host_addr)});
      end
    end
  end

  // Pop and compare whenever a read result is presented
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (bus.vid_rvalid) begin
      vid_run++;
      vid_rv_total++;
      if (vid_run > max_run) max_run = vid_run;
    end else begin
      vid_run = 0;
    end
    if (bus.host_rvalid) host_rv_total++;
    if (bus.vid_rvalid || bus.host_rvalid) begin
      chk("rvalid_exclusive", {31'd0, bus.vid_rvalid & bus.host_rvalid}, 32'd0);
      if (sb.size() == 0) begin
        chk("sb_unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_port", {31'd0, bus.vid_rvalid}, {31'd0, e.is_vid});
        chk("sb_data", {16'd0, bus.rd_data}, {16'd0, e.data});
      end
    end
  end

  typedef struct {
    bit       vr, hr, we;
    bit [1:0] be;
    bit       exp_vg, exp_hg, exp_ce, exp_we, exp_lb, exp_hb;
  } vec_t;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clear_reqs();
    bus.vid_req  = 1'b0;
    bus.host_req = 1'b0;
    bus.host_we  = 1'b0;
  endtask

  initial begin
    vec_t vt[8];
    int   vg_cnt;
    bit   got;
    int   v0, h0;

    vt[0] = '{1, 0, 0, 2'b11, 1, 0, 1, 0, 1, 1};
    vt[1] = '{0, 1, 0, 2'b11, 0, 1, 1, 0, 1, 1};
    vt[2] = '{0, 1, 1, 2'b01, 0, 1, 1, 1, 1, 0};
    vt[3] = '{0, 1, 1, 2'b10, 0, 1, 1, 1, 0, 1};
    vt[4] = '{0, 1, 1, 2'b00, 0, 1, 1, 1, 0, 0};
    vt[5] = '{1, 1, 0, 2'b11, 1, 0, 1, 0, 1, 1};
    vt[6] = '{1, 1, 1, 2'b01, 1, 0, 1, 0, 1, 1};
    vt[7] = '{0, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0};

    reset = 1'b1;
    bus.vid_req = 1'b1;  bus.host_req = 1'b1;  bus.host_we = 1'b0;
    bus.vid_addr = 18'h00010;  bus.host_addr = 18'h00020;
    bus.host_wdata = 16'h0000; bus.host_be = 2'b11;
    idle(3);
    #1;
    chk("rst_vid_gnt", {31'd0, bus.vid_gnt}, 32'd0);
    chk("rst_host_gnt", {31'd0, bus.host_gnt}, 32'd0);
    chk("rst_strobes", {27'd0, bus.ram_ce, bus.ram_oe, bus.ram_we, bus.ram_lb, bus.ram_hb}, 32'd0);
    chk("rst_addr_dout", {bus.ram_addr[15:0], bus.ram_dout}, 32'd0);
    chk("rst_rd_data", {16'd0, bus.rd_data}, 32'd0);
    chk("rst_rvalid", {30'd0, bus.vid_rvalid, bus.host_rvalid}, 32'd0);

    @(negedge clk);
    reset = 1'b0;
    clear_reqs();
    idle(2);

    // Arbitration vector table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.vid_req = vt[i].vr;  bus.host_req = vt[i].hr;  bus.host_we = vt[i].we;
      bus.host_be = vt[i].be;
      bus.vid_addr = 18'h01000 + 18'(i);  bus.host_addr = 18'h02000 + 18'(i);
      bus.host_wdata = 16'hC000 + 16'(i);
      #1;
      chk($sformatf("vec%0d_gnt", i), {30'd0, bus.vid_gnt, bus.host_gnt}, {30'd0, vt[i].exp_vg, vt[i].exp_hg});
      @(negedge clk);
      clear_reqs();
      #1;
      chk($sformatf("vec%0d_strobe", i), {28'd0, bus.ram_ce, bus.ram_we, bus.ram_lb, bus.ram_hb},
          {28'd0, vt[i].exp_ce, vt[i].exp_we, vt[i].exp_lb, vt[i].exp_hb});
      if (vt[i].exp_ce)
        chk($sformatf("vec%0d_addr", i), {14'd0, bus.ram_addr},
            {14'd0, (vt[i].exp_vg ? bus.vid_addr : bus.host_addr)});
      idle(3);
    end

    // Single video read with known data
    @(negedge clk);
    bus.vid_req = 1'b1;  bus.vid_addr = 18'h02040;
    @(negedge clk);
    bus.vid_req = 1'b0;
    #1;
    chk("vrd_n1_addr", {14'd0, bus.ram_addr}, 32'h00002040);
    chk("vrd_n1_ce_oe_we", {29'd0, bus.ram_ce, bus.ram_oe, bus.ram_we}, 32'b110);
    chk("vrd_n1_no_rvalid", {31'd0, bus.vid_rvalid}, 32'd0);
    @(negedge clk);
    #1;
    chk("vrd_n2_rvalid", {31'd0, bus.vid_rvalid}, 32'd1);
    chk("vrd_n2_data", {16'd0, bus.rd_data}, 32'h0000A5A5);
    @(negedge clk);
    #1;
    chk("vrd_n3_rvalid_low", {31'd0, bus.vid_rvalid}, 32'd0);
    idle(2);

    // Host write then video request rising during WR
    @(negedge clk);
    bus.host_req = 1'b1;  bus.host_we = 1'b1;  bus.host_addr = 18'h00200;
    bus.host_wdata = 16'hBEEF;  bus.host_be = 2'b11;
    #1;
    chk("wv_host_gnt", {31'd0, bus.host_gnt}, 32'd1);
    @(negedge clk);
    clear_reqs();
    bus.vid_req = 1'b1;  bus.vid_addr = 18'h03333;
    #1;
    chk("wv_n1_vid_gnt_low", {31'd0, bus.vid_gnt}, 32'd0);
    chk("wv_n1_we", {31'd0, bus.ram_we}, 32'd1);
    @(negedge clk);
    #1;
    chk("wv_n2_vid_gnt", {31'd0, bus.vid_gnt}, 32'd1);
    chk("wv_n2_hold", {30'd0, bus.ram_ce, bus.ram_we}, 32'b10);
    @(negedge clk);
    bus.vid_req = 1'b0;
    #1;
    chk("wv_n3_addr", {14'd0, bus.ram_addr}, 32'h00003333);
    chk("wv_n3_oe", {30'd0, bus.ram_oe, bus.ram_we}, 32'b10);
    idle(3);

    // Host write with single byte lane and hold phase
    @(negedge clk);
    bus.host_req = 1'b1;  bus.host_we = 1'b1;  bus.host_addr = 18'h00100;
    bus.host_wdata = 16'h1234;  bus.host_be = 2'b01;
    #1;
    chk("hw_gnt", {31'd0, bus.host_gnt}, 32'd1);
    @(negedge clk);
    bus.vid_req = 1'b1;
    #1;
    chk("hw_n1_gnts_low", {30'd0, bus.vid_gnt, bus.host_gnt}, 32'd0);
    chk("hw_n1_strobes", {27'd0, bus.ram_ce, bus.ram_oe, bus.ram_we, bus.ram_lb, bus.ram_hb}, 32'b10110);
    chk("hw_n1_addr_data", {bus.ram_addr[15:0], bus.ram_dout}, 32'h01001234);
    clear_reqs();
    @(negedge clk);
    #1;
    chk("hw_n2_strobes", {27'd0, bus.ram_ce, bus.ram_oe, bus.ram_we, bus.ram_lb, bus.ram_hb}, 32'b10010);
    chk("hw_n2_addr_data", {bus.ram_addr[15:0], bus.ram_dout}, 32'h01001234);
    @(negedge clk);
    #1;
    chk("hw_idle_strobes", {29'd0, bus.ram_ce, bus.ram_oe, bus.ram_we}, 32'd0);
    chk("hw_idle_held", {bus.ram_addr[15:0], bus.ram_dout}, 32'h01001234);
    idle(2);

    // Starvation guard: both requesting continuously
    vg_cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      bus.vid_req = 1'b1;  bus.host_req = 1'b1;  bus.host_we = 1'b0;
      bus.vid_addr = 18'h05000 + 18'(i);  bus.host_addr = 18'h06000 + 18'(i);
      #1;
      if (bus.host_gnt) got = 1'b1;
      else if (bus.vid_gnt) vg_cnt++;
    end
    chk("starve_host_granted", {31'd0, got}, 32'd1);
    chk("starve_vid_grants", vg_cnt, 32'd16);
    @(negedge clk);
    bus.vid_addr = 18'h05100;
    #1;
    chk("starve_vid_resumes", {30'd0, bus.vid_gnt, bus.host_gnt}, 32'b10);
    @(negedge clk);
    clear_reqs();
    idle(4);

    // 40 back-to-back video reads
    v0 = vid_rv_total;
    h0 = host_rv_total;
    max_run = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.vid_req = 1'b1;
      bus.vid_addr = 18'h04000 + 18'(i * 7);
    end
    @(negedge clk);
    clear_reqs();
    idle(5);
    chk("b2b_vid_rvalid_count", vid_rv_total - v0, 32'd40);
    chk("b2b_consecutive", max_run, 32'd40);
    chk("b2b_no_host_rvalid", host_rv_total - h0, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);

    // Reset asserted in WR
    @(negedge clk);
    bus.host_req = 1'b1;  bus.host_we = 1'b1;  bus.host_addr = 18'h00300;
    bus.host_wdata = 16'h5555;  bus.host_be = 2'b11;
    @(negedge clk);
    reset = 1'b1;
    bus.vid_req = 1'b1;
    #1;
    chk("rwr_we_before", {31'd0, bus.ram_we}, 32'd1);
    chk("rwr_gnts_in_reset", {30'd0, bus.vid_gnt, bus.host_gnt}, 32'd0);
    @(negedge clk);
    #1;
    chk("rwr_strobes", {29'd0, bus.ram_ce, bus.ram_oe, bus.ram_we}, 32'd0);
    chk("rwr_rvalid", {30'd0, bus.vid_rvalid, bus.host_rvalid}, 32'd0);
    reset = 1'b0;
    clear_reqs();
    @(negedge clk);
    bus.vid_req = 1'b1;  bus.vid_addr = 18'h00777;
    #1;
    chk("rwr_idle_grant", {31'd0, bus.vid_gnt}, 32'd1);

    // Reset asserted in RD drops the pending rvalid
    @(negedge clk);
    bus.vid_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rrd_rvalid_suppressed", {30'd0, bus.vid_rvalid, bus.host_rvalid}, 32'd0);
    sb.delete();
    @(negedge clk);
    #1;
    chk("rrd_rvalid_still_low", {31'd0, bus.vid_rvalid}, 32'd0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
